// File: rtl/operation_sequencer.sv
// Control FSM for the shared mul/div/sqrt datapath: latches an op on start,
// sequences LOAD -> RUN (-> FIX for sqrt) -> DONE/ERR, and holds the result until ack.
module operation_sequencer #(
  parameter int N = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              op,
  input  logic                    divisor_zero,
  input  logic                    ack,
  output logic                    load_en,
  output logic                    step_en,
  output logic [1:0]              op_sel,
  output logic                    ov_count,
  output logic [$clog2(N+1)-1:0]  count,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int CW = $clog2(N+1);
  localparam logic [CW-1:0] ITER_FULL = CW'(N);
  localparam logic [CW-1:0] ITER_HALF = CW'(N/2);

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_SQRT = 2'b10;
  localparam logic [1:0] OP_ILL  = 2'b11;

  if ((N < 2) || ((N % 2) != 0)) begin : g_bad_n
    $error("operation_sequencer: N must be even and >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_FIX,
    S_DONE,
    S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      op_sel_q, op_sel_d;
  logic [CW-1:0]   count_q, count_d;

  always_comb begin
    state_d  = state_q;
    op_sel_d = op_sel_q;
    count_d  = count_q;
    load_en  = 1'b0;
    step_en  = 1'b0;
    ov_count = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_sel_d = op;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        load_en = 1'b1;
        busy    = 1'b1;
        if ((op_sel_q == OP_ILL) || ((op_sel_q == OP_DIV) && divisor_zero)) begin
          state_d = S_ERR;
        end else begin
          count_d = (op_sel_q == OP_SQRT) ? ITER_HALF : ITER_FULL;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        step_en = 1'b1;
        busy    = 1'b1;
        if (count_q != '0) begin
          count_d = count_q - CW'(1);
        end
        // Leave on the last iteration; a zero count also exits so the FSM cannot stall.
        if (count_q <= CW'(1)) begin
          state_d = (op_sel_q == OP_SQRT) ? S_FIX : S_DONE;
        end
      end
      S_FIX: begin
        step_en  = 1'b1;
        ov_count = 1'b1;
        busy     = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (ack) begin
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
        done  = 1'b1;
        error = 1'b1;
        if (ack) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      op_sel_q <= OP_MUL;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_sel_q <= op_sel_d;
      count_q  <= count_d;
    end
  end

  assign op_sel = op_sel_q;
  assign count  = count_q;

endmodule

// File: tb/tb_operation_sequencer.sv
// Directed bench for operation_sequencer (N=4): each step checks the full output
// vector {load_en, step_en, op_sel, ov_count, count, busy, done, error}.
module tb_operation_sequencer;

  localparam int N  = 4;
  localparam int CW = $clog2(N+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    op;
  logic          divisor_zero;
  logic          ack;
  logic          load_en, step_en, ov_count, busy, done, error;
  logic [1:0]    op_sel;
  logic [CW-1:0] count;

  int total = 0;
  int bad   = 0;

  operation_sequencer #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op           (op),
    .divisor_zero (divisor_zero),
    .ack          (ack),
    .load_en      (load_en),
    .step_en      (step_en),
    .op_sel       (op_sel),
    .ov_count     (ov_count),
    .count        (count),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  // Expected vector layout: load,step,op_sel[1:0],ov,count[2:0],busy,done,error
  function automatic logic [10:0] ev(input int ld, input int st, input int os, input int ov,
                                     input int cn, input int bz, input int dn, input int er);
    ev = {ld[0], st[0], os[1:0], ov[0], cn[2:0], bz[0], dn[0], er[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [10:0] exp);
    logic [10:0] obs;
    obs = {load_en, step_en, op_sel, ov_count, count, busy, done, error};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; op = 2'b00; divisor_zero = 1'b0; ack = 1'b0;
    tick(); tick();
    check("reset", ev(0,0,0,0,0,0,0,0));
    rst = 1'b1;
    tick();
    check("idle", ev(0,0,0,0,0,0,0,0));

    // 1: multiply; op changes after latch must not reach op_sel
    start = 1'b1; op = 2'b00;
    tick(); start = 1'b0; op = 2'b11;
    check("mul_load", ev(1,0,0,0,0,1,0,0));
    tick(); check("mul_run4", ev(0,1,0,0,4,1,0,0));
    tick(); check("mul_run3", ev(0,1,0,0,3,1,0,0));
    tick(); check("mul_run2", ev(0,1,0,0,2,1,0,0));
    tick(); check("mul_run1", ev(0,1,0,0,1,1,0,0));
    tick(); check("mul_done", ev(0,0,0,0,0,0,1,0));
    start = 1'b1;
    tick(); check("mul_done_hold_start_ignored", ev(0,0,0,0,0,0,1,0));
    start = 1'b0; ack = 1'b1;
    tick(); ack = 1'b0;
    check("mul_idle", ev(0,0,0,0,0,0,0,0));

    // 2a: divide, nonzero divisor
    start = 1'b1; op = 2'b01;
    tick(); start = 1'b0;
    check("div_load", ev(1,0,1,0,0,1,0,0));
    tick(); check("div_run4", ev(0,1,1,0,4,1,0,0));
    tick(); tick(); tick();
    check("div_run1", ev(0,1,1,0,1,1,0,0));
    tick(); check("div_done", ev(0,0,1,0,0,0,1,0));
    ack = 1'b1; tick(); ack = 1'b0;
    check("div_idle", ev(0,0,1,0,0,0,0,0));

    // 2b: divide by zero
    start = 1'b1; op = 2'b01;
    tick(); start = 1'b0; divisor_zero = 1'b1;
    check("dz_load", ev(1,0,1,0,0,1,0,0));
    tick(); divisor_zero = 1'b0;
    check("dz_err", ev(0,0,1,0,0,0,1,1));
    tick(); check("dz_err_hold", ev(0,0,1,0,0,0,1,1));
    ack = 1'b1; tick(); ack = 1'b0;
    check("dz_idle", ev(0,0,1,0,0,0,0,0));

    // 3: square root with correction step
    start = 1'b1; op = 2'b10;
    tick(); start = 1'b0;
    check("sqrt_load", ev(1,0,2,0,0,1,0,0));
    tick(); check("sqrt_run2", ev(0,1,2,0,2,1,0,0));
    tick(); check("sqrt_run1", ev(0,1,2,0,1,1,0,0));
    tick(); check("sqrt_fix", ev(0,1,2,1,0,1,0,0));
    tick(); check("sqrt_done", ev(0,0,2,0,0,0,1,0));
    ack = 1'b1; tick(); ack = 1'b0;
    check("sqrt_idle", ev(0,0,2,0,0,0,0,0));

    // 4: illegal op
    start = 1'b1; op = 2'b11;
    tick(); start = 1'b0; op = 2'b00;
    check("ill_load", ev(1,0,3,0,0,1,0,0));
    tick(); check("ill_err", ev(0,0,3,0,0,0,1,1));
    ack = 1'b1; tick(); ack = 1'b0;
    check("ill_idle", ev(0,0,3,0,0,0,0,0));

    // 5: reset mid-run, start pulses ignored
    start = 1'b1; op = 2'b00;
    tick(); start = 1'b0;
    check("rst_load", ev(1,0,0,0,0,1,0,0));
    tick(); start = 1'b1;
    check("rst_run4", ev(0,1,0,0,4,1,0,0));
    tick(); check("rst_run3_start_ignored", ev(0,1,0,0,3,1,0,0));
    rst = 1'b0;
    tick(); check("rst_midrun", ev(0,0,0,0,0,0,0,0));
    tick(); check("rst_held", ev(0,0,0,0,0,0,0,0));
    rst = 1'b1; start = 1'b0;
    tick(); check("rst_release_idle", ev(0,0,0,0,0,0,0,0));

    // 6: done held without ack, then ack+start together, then restart
    start = 1'b1; op = 2'b00;
    tick(); start = 1'b0;
    tick(); tick(); tick(); tick();
    tick(); check("hold_done1", ev(0,0,0,0,0,0,1,0));
    tick(); check("hold_done2", ev(0,0,0,0,0,0,1,0));
    tick(); check("hold_done3", ev(0,0,0,0,0,0,1,0));
    ack = 1'b1; start = 1'b1; op = 2'b10;
    tick(); ack = 1'b0;
    check("ack_wins_idle", ev(0,0,0,0,0,0,0,0));
    tick(); start = 1'b0;
    check("restart_load", ev(1,0,2,0,0,1,0,0));
    tick(); tick(); tick();
    check("restart_fix", ev(0,1,2,1,0,1,0,0));
    tick(); check("restart_done", ev(0,0,2,0,0,0,1,0));
    ack = 1'b1; tick(); ack = 1'b0;
    check("restart_idle", ev(0,0,2,0,0,0,0,0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
